// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: opcode-fetch handshake, step FSM and one-hot datapath strobes for MOV/MVI/ALU/HLT.
// Build option: define CTRL_ALU_EN to execute the 10ooosss ALU group; otherwise it decodes as illegal.
module ctrl_sequencer #(
    parameter int IMM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] ir_data,
    input  logic       ir_valid,
    output logic       ir_ready,
    input  logic       imm_valid,
    output logic       imm_ready,
    output logic       data_in_select,
    output logic [6:0] reg_select,
    output logic [6:0] reg_enable,
    output logic       r1_enable,
    output logic       r2_enable,
    output logic       r2_select,
    output logic [2:0] alu_op,
    output logic       done,
    output logic       error,
    output logic       halted
);

    localparam logic [3:0] ST_FETCH = 4'd0;
    localparam logic [3:0] ST_MOV   = 4'd1;
    localparam logic [3:0] ST_IMM   = 4'd2;
    localparam logic [3:0] ST_MWB   = 4'd3;
    localparam logic [3:0] ST_HLT1  = 4'd4;
    localparam logic [3:0] ST_HALT  = 4'd5;
    localparam logic [3:0] ST_ILL   = 4'd6;
    localparam logic [3:0] ST_TMO   = 4'd7;
`ifdef CTRL_ALU_EN
    localparam logic [3:0] ST_AL1   = 4'd8;
    localparam logic [3:0] ST_AL2   = 4'd9;
    localparam logic [3:0] ST_AL3   = 4'd10;
`endif

    localparam logic [2:0]      REG_M   = 3'b110;
    localparam logic [7:0]      OP_HLT  = 8'h76;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IMM_TIMEOUT - 1);
    localparam bit              TO_EN   = (IMM_TIMEOUT != 0);

    logic [3:0]      state_r;
    logic [3:0]      nextState_s;
    logic [5:0]      irQ_r;
    logic [TO_W-1:0] toCnt_r;

    // Register code to one-hot strobe; code 110 (M) has no register and yields zero.
    function automatic logic [6:0] regOneHot(input logic [2:0] code);
        logic [6:0] oh;
        case (code)
            3'b000:  oh = 7'b0000001;
            3'b001:  oh = 7'b0000010;
            3'b010:  oh = 7'b0000100;
            3'b011:  oh = 7'b0001000;
            3'b100:  oh = 7'b0010000;
            3'b101:  oh = 7'b0100000;
            3'b111:  oh = 7'b1000000;
            default: oh = 7'b0000000;
        endcase
        return oh;
    endfunction

    // First execution state for an accepted opcode.
    function automatic logic [3:0] decodeOp(input logic [7:0] op);
        logic [3:0] st;
        case (op[7:6])
            2'b00: begin
                if (op[2:0] == REG_M && op[5:3] != REG_M) st = ST_IMM;
                else                                      st = ST_ILL;
            end
            2'b01: begin
                if (op == OP_HLT)                                st = ST_HLT1;
                else if (op[2:0] != REG_M && op[5:3] != REG_M)   st = ST_MOV;
                else                                             st = ST_ILL;
            end
`ifdef CTRL_ALU_EN
            2'b10: begin
                if (op[2:0] != REG_M) st = ST_AL1;
                else                  st = ST_ILL;
            end
`endif
            default: st = ST_ILL;
        endcase
        return st;
    endfunction

    // Next-state logic; imm_valid beats a timeout expiring in the same cycle.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (ir_valid) nextState_s = decodeOp(ir_data);
                else          nextState_s = ST_FETCH;
            end
            ST_IMM: begin
                if (imm_valid)                          nextState_s = ST_MWB;
                else if (TO_EN && (toCnt_r == TO_LAST)) nextState_s = ST_TMO;
                else                                    nextState_s = ST_IMM;
            end
            ST_MOV, ST_MWB, ST_ILL, ST_TMO: nextState_s = ST_FETCH;
            ST_HLT1, ST_HALT:               nextState_s = ST_HALT;
`ifdef CTRL_ALU_EN
            ST_AL1: nextState_s = ST_AL2;
            ST_AL2: nextState_s = ST_AL3;
            ST_AL3: nextState_s = ST_FETCH;
`endif
            default: nextState_s = ST_FETCH;
        endcase
    end

    // State, latched opcode and wait counter; the counter only runs inside IMM so it is zero on entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_FETCH;
            irQ_r   <= 6'd0;
            toCnt_r <= {TO_W{1'b0}};
        end else begin
            state_r <= nextState_s;
            if (state_r == ST_FETCH && ir_valid) begin
                irQ_r <= ir_data[5:0];
            end
            if (state_r == ST_IMM) begin
                toCnt_r <= toCnt_r + TO_W'(1);
            end else begin
                toCnt_r <= {TO_W{1'b0}};
            end
        end
    end

    // Output decode from state and latched opcode; IMM additionally follows imm_valid.
    always_comb begin
        ir_ready       = 1'b0;
        imm_ready      = 1'b0;
        data_in_select = 1'b0;
        reg_select     = 7'b0000000;
        reg_enable     = 7'b0000000;
        r1_enable      = 1'b0;
        r2_enable      = 1'b0;
        r2_select      = 1'b0;
        alu_op         = 3'b000;
        done           = 1'b0;
        error          = 1'b0;
        halted         = 1'b0;
        case (state_r)
            ST_FETCH: ir_ready = 1'b1;
            ST_MOV: begin
                reg_select = regOneHot(irQ_r[2:0]);
                reg_enable = regOneHot(irQ_r[5:3]);
                done       = 1'b1;
            end
            ST_IMM: begin
                data_in_select = 1'b1;
                imm_ready      = imm_valid;
                if (imm_valid) reg_enable = regOneHot(irQ_r[5:3]);
                else           reg_enable = 7'b0000000;
            end
            ST_MWB: begin
                reg_select = regOneHot(irQ_r[5:3]);
                done       = 1'b1;
            end
`ifdef CTRL_ALU_EN
            ST_AL1: begin
                reg_select = 7'b1000000;
                r1_enable  = 1'b1;
            end
            ST_AL2: begin
                reg_select = regOneHot(irQ_r[2:0]);
                r2_enable  = 1'b1;
            end
            ST_AL3: begin
                r2_select  = 1'b1;
                alu_op     = irQ_r[5:3];
                reg_enable = 7'b1000000;
                done       = 1'b1;
            end
`endif
            ST_HLT1: begin
                done   = 1'b1;
                halted = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            ST_ILL: begin
                error = 1'b1;
                done  = 1'b1;
            end
            ST_TMO:  error = 1'b1;
            default: ir_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed and random opcodes against an instruction-level trace model.
module tb_ctrl_sequencer;

    localparam int TMO = 5;
`ifdef CTRL_ALU_EN
    localparam bit ALU_EN = 1'b1;
`else
    localparam bit ALU_EN = 1'b0;
`endif
    localparam int K_MOV = 0, K_MVI = 1, K_ALU = 2, K_HLT = 3, K_ILL = 4;

    typedef struct packed {
        logic       irReady;
        logic       immReady;
        logic       dsel;
        logic [6:0] rsel;
        logic [6:0] ren;
        logic       r1;
        logic       r2;
        logic       r2s;
        logic [2:0] aluOp;
        logic       done;
        logic       err;
        logic       halted;
    } outs_t;

    typedef struct packed {
        logic       irV;
        logic [7:0] irD;
        logic       immV;
        outs_t      exp;
    } step_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] ir_data;
    logic       ir_valid, ir_ready, imm_valid, imm_ready, data_in_select;
    logic [6:0] reg_select, reg_enable;
    logic       r1_enable, r2_enable, r2_select, done, error, halted;
    logic [2:0] alu_op;
    outs_t      obs;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.IMM_TIMEOUT(TMO), .TO_W(8)) dut (
        .clk(clk), .resetn(resetn), .ir_data(ir_data), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .imm_valid(imm_valid), .imm_ready(imm_ready), .data_in_select(data_in_select),
        .reg_select(reg_select), .reg_enable(reg_enable), .r1_enable(r1_enable),
        .r2_enable(r2_enable), .r2_select(r2_select), .alu_op(alu_op), .done(done),
        .error(error), .halted(halted)
    );

    assign obs = {ir_ready, imm_ready, data_in_select, reg_select, reg_enable,
                  r1_enable, r2_enable, r2_select, alu_op, done, error, halted};

    function automatic logic [6:0] sel(input int code);
        if (code == 7) return 7'h40;
        else           return 7'(1 << code);
    endfunction

    function automatic int kindOf(input logic [7:0] op);
        int grp, d, s;
        grp = int'(op) / 64;
        d   = (int'(op) / 8) % 8;
        s   = int'(op) % 8;
        if (op == 8'h76)                      return K_HLT;
        if (grp == 1 && d != 6 && s != 6)     return K_MOV;
        if (grp == 0 && s == 6 && d != 6)     return K_MVI;
        if (grp == 2 && s != 6 && ALU_EN)     return K_ALU;
        return K_ILL;
    endfunction

    function automatic outs_t idle();
        outs_t o = '0;
        o.irReady = 1'b1;
        return o;
    endfunction

    function automatic step_t blank();
        step_t b = '0;
        b.irD  = 8'($urandom);
        b.immV = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic check(input string tag, input outs_t e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic play(input step_t s, input string tag);
        @(posedge clk);
        #1;
        ir_valid  = s.irV;
        ir_data   = s.irD;
        imm_valid = s.immV;
        #2;
        check(tag, s.exp);
    endtask

    // w = cycles imm_valid is withheld in MVI; stopAfter < 0 plays the whole trace.
    task automatic runInstr(input logic [7:0] op, input int w, input int stopAfter);
        step_t q[$];
        step_t s;
        int    d, sr, n;
        d  = (int'(op) / 8) % 8;
        sr = int'(op) % 8;
        s = '0; s.irV = 1'b1; s.irD = op; s.immV = 1'($urandom_range(0, 1)); s.exp = idle();
        q.push_back(s);
        case (kindOf(op))
            K_MOV: begin
                s = blank(); s.exp.rsel = sel(sr); s.exp.ren = sel(d); s.exp.done = 1'b1; q.push_back(s);
            end
            K_MVI: begin
                n = (w < TMO) ? w : TMO;
                for (int i = 0; i < n; i++) begin
                    s = blank(); s.immV = 1'b0; s.exp.dsel = 1'b1; q.push_back(s);
                end
                if (w < TMO) begin
                    s = blank(); s.immV = 1'b1; s.exp.dsel = 1'b1; s.exp.immReady = 1'b1;
                    s.exp.ren = sel(d); q.push_back(s);
                    s = blank(); s.exp.rsel = sel(d); s.exp.done = 1'b1; q.push_back(s);
                end else begin
                    s = blank(); s.exp.err = 1'b1; q.push_back(s);
                end
            end
            K_ALU: begin
                s = blank(); s.exp.rsel = sel(7); s.exp.r1 = 1'b1; q.push_back(s);
                s = blank(); s.exp.rsel = sel(sr); s.exp.r2 = 1'b1; q.push_back(s);
                s = blank(); s.exp.r2s = 1'b1; s.exp.aluOp = 3'(d); s.exp.ren = sel(7);
                s.exp.done = 1'b1; q.push_back(s);
            end
            K_HLT: begin
                s = blank(); s.exp.done = 1'b1; s.exp.halted = 1'b1; q.push_back(s);
                for (int i = 0; i < 10; i++) begin
                    s = blank(); s.irV = 1'($urandom_range(0, 1)); s.irD = 8'h41;
                    s.exp.halted = 1'b1; q.push_back(s);
                end
            end
            default: begin
                s = blank(); s.exp.err = 1'b1; s.exp.done = 1'b1; q.push_back(s);
            end
        endcase
        foreach (q[i]) begin
            if (stopAfter < 0 || i <= stopAfter) play(q[i], $sformatf("op%02h_c%0d", op, i));
        end
    endtask

    initial begin
        logic [7:0] op;
        resetn    = 1'b0;
        ir_valid  = 1'b0;
        ir_data   = 8'h00;
        imm_valid = 1'b0;
        #3;
        check("reset", idle());
        @(posedge clk);
        #2;
        resetn = 1'b1;

        runInstr(8'h41, 0, -1);
        runInstr(8'h3E, 3, -1);
        runInstr(8'h16, 99, -1);
        runInstr(8'h93, 0, -1);
        runInstr(8'h46, 0, -1);
        runInstr(8'h06, 0, -1);
        runInstr(8'h0E, TMO - 1, -1);
        runInstr(8'h36, 0, -1);
        runInstr(8'h96, 0, -1);
        runInstr(8'h7F, 0, -1);
        runInstr(8'h78, 0, -1);

        for (int i = 0; i < 80; i++) begin
            do op = 8'($urandom); while (op == 8'h76);
            runInstr(op, $urandom_range(0, TMO + 1), -1);
        end

        // Abort mid-instruction with an asynchronous reset.
        if (ALU_EN) runInstr(8'h93, 0, 2);
        else        runInstr(8'h3E, 9, 2);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_async", idle());
        @(posedge clk);
        #1;
        check("rst_hold", idle());
        resetn = 1'b1;
        runInstr(8'h41, 0, -1);

        runInstr(8'h76, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
